// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: VGA raster engine that draws a GRID_W x GRID_H cell map
// (BPP bits per cell) through a fixed 4-entry palette onto an 8-bit RGB DAC.
// Pixel timing runs on a clock enable derived from clk_50 (no generated clock).
// Cell addressing uses incremental counters, so no divide or multiply by SCALE.
// The cell map is sampled into a shadow register once per frame, at the end of
// the last active line, so a frame never shows a mix of two maps.
// Video and sync pass through the same two-stage pipeline so they stay aligned.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces the picture with eight vertical colour bars.
module vga_tile_renderer #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int GRID_W    = 80,
  parameter int GRID_H    = 24,
  parameter int SCALE_X   = 8,
  parameter int SCALE_Y   = 20,
  parameter int BPP       = 1,
  parameter int CLK_DIV   = 2
) (
  input  logic                           clk_50,
  input  logic                           rst,
  input  logic [GRID_W*GRID_H*BPP-1:0]   game_display,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                           test_mode,
`endif
  output logic                           hsync,
  output logic                           vsync,
  output logic [7:0]                     VGA_R,
  output logic [7:0]                     VGA_G,
  output logic [7:0]                     VGA_B,
  output logic                           VGA_BLANK_N,
  output logic                           VGA_SYNC_N,
  output logic                           VGA_CLK,
  output logic                           frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int SXW     = $clog2(SCALE_X + 1);
  localparam int SYW     = $clog2(SCALE_Y + 1);
  localparam int NCELL   = GRID_W * GRID_H;
  localparam int CIW     = $clog2(NCELL);

  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT   = HW'(H_DISPLAY);
  localparam logic [HW-1:0]  HS_BEG  = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0]  HS_END  = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT   = VW'(V_DISPLAY);
  localparam logic [VW-1:0]  V_LATCH = VW'(V_DISPLAY - 1);
  localparam logic [VW-1:0]  VS_BEG  = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0]  VS_END  = VW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);
  localparam logic [HW-1:0]  GX_LIM  = HW'(GRID_W);
  localparam logic [VW-1:0]  GY_LIM  = VW'(GRID_H);
  localparam logic [CIW-1:0] ROW_STEP = CIW'(GRID_W);

  // Timing and addressing state
  logic [DW-1:0]  r_div_cnt;
  logic           r_vga_clk;
  logic [HW-1:0]  r_h;
  logic [VW-1:0]  r_v;
  logic [SXW-1:0] r_sub_x;
  logic [HW-1:0]  r_cell_x;
  logic [SYW-1:0] r_sub_y;
  logic [VW-1:0]  r_cell_y;
  logic [CIW-1:0] r_row_base;   // cell_y * GRID_W, kept incrementally

  // Frame-coherent copy of the cell map
  logic [NCELL*BPP-1:0] r_shadow;
  logic                 r_frame_start;

  // Pipeline stage 1: cell fetch and pre-delay sync state
  logic           r_s1_active;
  logic [BPP-1:0] r_s1_bits;
  logic           r_s1_hs;
  logic           r_s1_vs;

  // Pipeline stage 2: output registers
  logic           r_hsync;
  logic           r_vsync;
  logic           r_blank_n;
  logic [23:0]    r_rgb;

  logic           w_pix_ce;
  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           w_latch;
  logic           w_in_grid;
  logic [CIW-1:0] w_cell_idx;
  logic [BPP-1:0] w_cell_bits;
  logic [BPP-1:0] w_cells [NCELL];
  logic [23:0]    w_rgb;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_DISPLAY / 8;
  localparam int BWW   = $clog2(BAR_W + 1);
  localparam logic [BWW-1:0] BAR_LAST = BWW'(BAR_W - 1);
  logic [BWW-1:0] r_bar_sub;
  logic [2:0]     r_bar;
  logic [2:0]     r_s1_bar;
`endif

  assign w_pix_ce = (r_div_cnt == DIV_LAST);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_latch  = w_pix_ce && w_h_wrap && (r_v == V_LATCH);

  // Clock divider, pixel clock output and raster/cell counters
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_vga_clk  <= 1'b0;
      r_h        <= '0;
      r_v        <= '0;
      r_sub_x    <= '0;
      r_cell_x   <= '0;
      r_sub_y    <= '0;
      r_cell_y   <= '0;
      r_row_base <= '0;
`ifdef VGA_TEST_PATTERN_EN
      r_bar_sub  <= '0;
      r_bar      <= '0;
`endif
    end else begin
      r_vga_clk <= (r_div_cnt >= DIV_HALF);
      if (w_pix_ce) r_div_cnt <= '0;
      else          r_div_cnt <= r_div_cnt + 1'b1;
      if (w_pix_ce) begin
        if (w_h_wrap) begin
          r_h      <= '0;
          r_sub_x  <= '0;
          r_cell_x <= '0;
`ifdef VGA_TEST_PATTERN_EN
          r_bar_sub <= '0;
          r_bar     <= '0;
`endif
          if (w_v_wrap) begin
            r_v        <= '0;
            r_sub_y    <= '0;
            r_cell_y   <= '0;
            r_row_base <= '0;
          end else begin
            r_v <= r_v + 1'b1;
            if (r_sub_y == SY_LAST) begin
              r_sub_y    <= '0;
              r_cell_y   <= r_cell_y + 1'b1;
              r_row_base <= r_row_base + ROW_STEP;
            end else begin
              r_sub_y <= r_sub_y + 1'b1;
            end
          end
        end else begin
          r_h <= r_h + 1'b1;
          if (r_sub_x == SX_LAST) begin
            r_sub_x  <= '0;
            r_cell_x <= r_cell_x + 1'b1;
          end else begin
            r_sub_x <= r_sub_x + 1'b1;
          end
`ifdef VGA_TEST_PATTERN_EN
          // Bar index may wrap in blanking; those pixels are forced black.
          if (r_bar_sub == BAR_LAST) begin
            r_bar_sub <= '0;
            r_bar     <= r_bar + 1'b1;
          end else begin
            r_bar_sub <= r_bar_sub + 1'b1;
          end
`endif
        end
      end
    end
  end

  // Shadow load at the end of the last active line, with a one-cycle marker
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_shadow      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_latch;
      if (w_latch) r_shadow <= game_display;
    end
  end

  // View the shadow as an array of cells so the fetch is a plain indexed read
  for (genvar k = 0; k < NCELL; k++) begin : g_cell
    assign w_cells[k] = r_shadow[k*BPP +: BPP];
  end

  // Row base wraps harmlessly below the grid; w_in_grid masks those reads.
  assign w_cell_idx  = r_row_base + CIW'(r_cell_x);
  assign w_in_grid   = (r_cell_x < GX_LIM) && (r_cell_y < GY_LIM);
  assign w_cell_bits = w_cells[w_cell_idx];

  // Stage 1: fetch the cell under the beam and its pre-delay sync/active state
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_s1_active <= 1'b0;
      r_s1_bits   <= '0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      r_s1_bar    <= '0;
`endif
    end else if (w_pix_ce) begin
      r_s1_active <= (r_h < H_ACT) && (r_v < V_ACT);
      r_s1_bits   <= w_in_grid ? w_cell_bits : '0;
      r_s1_hs     <= !((r_h >= HS_BEG) && (r_h < HS_END));
      r_s1_vs     <= !((r_v >= VS_BEG) && (r_v < VS_END));
`ifdef VGA_TEST_PATTERN_EN
      r_s1_bar    <= r_bar;
`endif
    end
  end

  // Colour selection for stage 2: palette, or colour bars in test mode
  always_comb begin
    w_rgb = 24'h000000;
    case (2'(r_s1_bits))
      2'd0:    w_rgb = 24'h000000;
      2'd1:    w_rgb = 24'hFFFFFF;
      2'd2:    w_rgb = 24'h00FF00;
      default: w_rgb = 24'hFF0000;
    endcase
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      case (r_s1_bar)
        3'd0:    w_rgb = 24'hFFFFFF;
        3'd1:    w_rgb = 24'hFFFF00;
        3'd2:    w_rgb = 24'h00FFFF;
        3'd3:    w_rgb = 24'h00FF00;
        3'd4:    w_rgb = 24'hFF00FF;
        3'd5:    w_rgb = 24'hFF0000;
        3'd6:    w_rgb = 24'h0000FF;
        default: w_rgb = 24'h000000;
      endcase
    end
`endif
  end

  // Stage 2: register colour and the delayed sync/blank state
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (w_pix_ce) begin
      r_hsync   <= r_s1_hs;
      r_vsync   <= r_s1_vs;
      r_blank_n <= r_s1_active;
      r_rgb     <= r_s1_active ? w_rgb : 24'h000000;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = r_vga_clk;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer. A reduced-timing instance (24x12 raster,
// 3x3 grid of 4x2-pixel cells, BPP=2) exercises rendering, shadow latching,
// sync alignment and mid-frame reset; a default-parameter instance checks the
// 640x480 horizontal sync timing. Output for pixel P (pixels counted from reset
// release) is sampled at the falling edge after rising edge 2*(P+2).
module tb_vga_tile_renderer;

  localparam int HT    = 24;
  localparam int FRAME = 24 * 12;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic        rst;
  logic [17:0] gd;
  logic [1919:0] gd_def;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode;
`endif

  logic       hsync, vsync, blank_n, sync_n, vga_clk, fs;
  logic [7:0] vr, vg, vb;
  logic       hs_d, vs_d, blank_d, sync_d, clk_d, fs_d;
  logic [7:0] r_d, g_d, b_d;

  vga_tile_renderer #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .GRID_W(3), .GRID_H(3), .SCALE_X(4), .SCALE_Y(2), .BPP(2), .CLK_DIV(2)
  ) dut (
    .clk_50(clk_50), .rst(rst), .game_display(gd),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .hsync(hsync), .vsync(vsync), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
    .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .VGA_CLK(vga_clk),
    .frame_start(fs)
  );

  vga_tile_renderer dut_def (
    .clk_50(clk_50), .rst(rst), .game_display(gd_def),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .hsync(hs_d), .vsync(vs_d), .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d),
    .VGA_BLANK_N(blank_d), .VGA_SYNC_N(sync_d), .VGA_CLK(clk_d),
    .frame_start(fs_d)
  );

  // Cycle count since reset release; bench time base only
  int cyc;
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_50);
  endtask

  task automatic at_pix(input int fr, input int h, input int v);
    wait_cyc(2 * (fr * FRAME + v * HT + h + 2));
  endtask

  task automatic chk_pix(input string tag, input int fr, input int h, input int v,
                         input logic [23:0] exp_rgb, input logic exp_blank);
    at_pix(fr, h, v);
    chk({tag, "_rgb"}, {vr, vg, vb}, exp_rgb);
    chk({tag, "_blank"}, blank_n, exp_blank);
  endtask

  task automatic chk_sync(input string tag, input int fr, input int h, input int v,
                          input logic exp_hs, input logic exp_vs);
    at_pix(fr, h, v);
    chk({tag, "_hs"}, hsync, exp_hs);
    chk({tag, "_vs"}, vsync, exp_vs);
  endtask

  initial begin
    int f1, r1, f2;
    logic prev;

    rst    = 1'b1;
    gd     = 18'h30009;   // cell(0,0)=1, cell(1,0)=2, cell(2,2)=3
    gd_def = '0;
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(negedge clk_50);

    // Reset state
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_rgb", {vr, vg, vb}, 24'h0);
    chk("rst_blank", blank_n, 1'b0);
    chk("rst_vgaclk", vga_clk, 1'b0);
    chk("rst_fs", fs, 1'b0);
    chk("rst_syncn", sync_n, 1'b0);
    chk("rst_def_hsync", hs_d, 1'b1);
    chk("rst_def_blank", blank_d, 1'b0);
    rst = 1'b0;

    // Pixel clock output follows the divider phase
    wait_cyc(2); chk("vgaclk_hi", vga_clk, 1'b1);
    wait_cyc(3); chk("vgaclk_lo", vga_clk, 1'b0);

    // First frame is black until the first shadow load
    chk_pix("f0_p00", 0, 0, 0, 24'h000000, 1'b1);
    chk_pix("f0_p40", 0, 4, 0, 24'h000000, 1'b1);
    chk_sync("f0_hs18", 0, 18, 0, 1'b0, 1'b1);

    // Shadow load pulse at end of line v=7
    wait_cyc(383); chk("fs_before", fs, 1'b0);
    wait_cyc(384); chk("fs_pulse", fs, 1'b1);
    wait_cyc(385); chk("fs_after", fs, 1'b0);

    // Frame 1 renders the latched map
    chk_pix("f1_p00", 1, 0, 0, 24'hFFFFFF, 1'b1);
    chk_pix("f1_p40", 1, 4, 0, 24'h00FF00, 1'b1);
    chk_pix("f1_p120", 1, 12, 0, 24'h000000, 1'b1);
    chk_pix("f1_p160", 1, 16, 0, 24'h000000, 1'b0);
    chk_pix("f1_p31", 1, 3, 1, 24'hFFFFFF, 1'b1);
    chk_sync("f1_hs17", 1, 17, 1, 1'b1, 1'b1);
    chk_sync("f1_hs18", 1, 18, 1, 1'b0, 1'b1);
    chk_sync("f1_hs21", 1, 21, 1, 1'b0, 1'b1);
    chk_sync("f1_hs22", 1, 22, 1, 1'b1, 1'b1);

    // New map mid-frame must not appear until after the next load
    gd = 18'h00003;       // cell(0,0)=3 only
    chk_pix("f1_p74", 1, 7, 4, 24'h000000, 1'b1);
    chk_pix("f1_p84", 1, 8, 4, 24'hFF0000, 1'b1);
    chk_pix("f1_p115", 1, 11, 5, 24'hFF0000, 1'b1);
    chk_pix("f1_p06", 1, 0, 6, 24'h000000, 1'b1);
    chk_pix("f1_p157", 1, 15, 7, 24'h000000, 1'b1);
    chk_pix("f1_p08", 1, 0, 8, 24'h000000, 1'b0);
    chk_sync("f1_vs238", 1, 23, 8, 1'b1, 1'b1);
    chk_sync("f1_vs09", 1, 0, 9, 1'b1, 1'b0);
    chk_sync("f1_vs2310", 1, 23, 10, 1'b1, 1'b0);
    chk_sync("f1_vs011", 1, 0, 11, 1'b1, 1'b1);

    // Frame 2 shows the new map; a transient change between loads is ignored
    chk_pix("f2_p00", 2, 0, 0, 24'hFF0000, 1'b1);
    chk_pix("f2_p40", 2, 4, 0, 24'h000000, 1'b1);
    at_pix(2, 0, 2);
    gd = 18'h15555;       // all cells 1
    chk_pix("f2_p43", 2, 4, 3, 24'h000000, 1'b1);
    at_pix(2, 0, 6);
    gd = 18'h00003;
    chk_pix("f3_p00", 3, 0, 0, 24'hFF0000, 1'b1);
    chk_pix("f3_p40", 3, 4, 0, 24'h000000, 1'b1);

    // Asynchronous reset in the middle of an hsync pulse
    chk_sync("f3_hs20", 3, 20, 0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hsync", hsync, 1'b1);
    chk("mid_rst_vsync", vsync, 1'b1);
    chk("mid_rst_rgb", {vr, vg, vb}, 24'h0);
    chk("mid_rst_blank", blank_n, 1'b0);
    chk("mid_rst_vgaclk", vga_clk, 1'b0);
    chk("mid_rst_fs", fs, 1'b0);
    repeat (2) @(negedge clk_50);
    rst = 1'b0;

    // Restart from h=v=0 with a cleared shadow, then the map returns
    chk_pix("r0_p00", 0, 0, 0, 24'h000000, 1'b1);
    chk_sync("r0_hs18", 0, 18, 0, 1'b0, 1'b1);
    chk_pix("r1_p00", 1, 0, 0, 24'hFF0000, 1'b1);

    // Default 640x480 timing: hsync period and low width in clk_50 cycles
    f1 = -1; r1 = -1; f2 = -1;
    prev = hs_d;
    for (int k = 1; k <= 5000 && f2 < 0; k++) begin
      @(negedge clk_50);
      if (prev && !hs_d) begin
        if (f1 < 0) f1 = k;
        else        f2 = k;
      end
      if (!prev && hs_d && f1 >= 0 && r1 < 0) r1 = k;
      prev = hs_d;
    end
    chk("def_hs_period", 32'(f2 - f1), 32'd1600);
    chk("def_hs_low", 32'(r1 - f1), 32'd192);
    chk("def_syncn", sync_d, 1'b0);

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    chk_pix("tp_white", 8, 0, 0, 24'hFFFFFF, 1'b1);
    chk_pix("tp_yellow", 8, 2, 0, 24'hFFFF00, 1'b1);
    chk_pix("tp_black", 8, 14, 0, 24'h000000, 1'b1);
    test_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
